// File: rtl/fpu_div_sched.sv
// fpu_div_sched
// Round-robin scheduler that shares one sequential FP divider among
// NUM_REQ requesters. One operation is in flight at a time. A +/-0
// divisor is answered locally with a signed infinity and the overflow
// flag, without starting the divider. A divider that never finishes is
// cut off after TIMEOUT wait cycles with a timeout response.
//
// Ports
//   clk, clrn           clock; synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot)
//   req_a, req_b        packed operands, requester i at [i*X +: X]
//   resp_valid          one-hot response valid towards the granted requester
//   resp_ready          per-requester response accept
//   resp_out            quotient, with resp_overflow/underflow/timeout flags
//   div_a, div_b        operands to the divider (held while it works)
//   div_start           one-cycle start pulse to the divider
//   div_done            divider result pulse, with div_out and its flags
//   busy                high whenever an operation is in progress
module fpu_div_sched #(
  parameter int X       = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*X-1:0] req_a,
  input  logic [NUM_REQ*X-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [X-1:0]         resp_out,
  output logic                 resp_overflow,
  output logic                 resp_underflow,
  output logic                 resp_timeout,
  output logic [X-1:0]         div_a,
  output logic [X-1:0]         div_b,
  output logic                 div_start,
  input  logic                 div_done,
  input  logic [X-1:0]         div_out,
  input  logic                 div_overflow,
  input  logic                 div_underflow,
  output logic                 busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int EW = (X == 64) ? 11 : 8;
  localparam int MW = X - 1 - EW;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]      WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [X-1:0]      a_q;
  logic [X-1:0]      b_q;
  logic [X-1:0]      res_q;
  logic              ovf_q;
  logic              unf_q;
  logic              tmo_q;
  logic [CW-1:0]     wait_cnt;
  logic              start_q;
  logic              busy_q;
  logic [NUM_REQ-1:0] resp_valid_q;

  logic [X-1:0]      a_arr [NUM_REQ];
  logic [X-1:0]      b_arr [NUM_REQ];
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     scan_idx;
  logic [X-1:0]      sel_a;
  logic [X-1:0]      sel_b;

  // Unpack the operand buses so the arbiter pick can index them directly.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*X +: X];
      b_arr[i] = req_b[i*X +: X];
    end
  end

  // Round-robin scan starting just after the last requester served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign sel_a = a_arr[pick_idx];
  assign sel_b = b_arr[pick_idx];

  // Accept is combinational so a requester is taken in the same cycle it is
  // picked; it is suppressed during reset so nothing is accepted and lost.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !clrn && pick_found) req_ready[pick_idx] = 1'b1;
  end

  // Single control process: arbitration accept, divider issue, bounded
  // wait and response hold. All handshake outputs except req_ready are
  // registered here.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= GW'(NUM_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      wait_cnt     <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant  <= pick_idx;
            a_q    <= sel_a;
            b_q    <= sel_b;
            busy_q <= 1'b1;
            // A +/-0 divisor never reaches the divider: signed infinity.
            if (sel_b[X-2:0] == '0) begin
              res_q        <= {sel_a[X-1] ^ sel_b[X-1], {EW{1'b1}}, {MW{1'b0}}};
              ovf_q        <= 1'b1;
              unf_q        <= 1'b0;
              tmo_q        <= 1'b0;
              resp_valid_q <= ONE_HOT0 << pick_idx;
              state        <= RESP;
            end else begin
              start_q <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          start_q  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          // A done arriving on the timeout cycle still delivers its result.
          if (div_done) begin
            res_q        <= div_out;
            ovf_q        <= div_overflow;
            unf_q        <= div_underflow;
            tmo_q        <= 1'b0;
            resp_valid_q <= ONE_HOT0 << grant;
            state        <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            res_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            tmo_q        <= 1'b1;
            resp_valid_q <= ONE_HOT0 << grant;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[grant]) begin
            last_grant   <= grant;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_out       = res_q;
  assign resp_overflow  = ovf_q;
  assign resp_underflow = unf_q;
  assign resp_timeout   = tmo_q;
  assign div_a          = a_q;
  assign div_b          = b_q;
  assign div_start      = start_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fpu_div_sched.sv
// Self-checking bench for fpu_div_sched (X=32, NUM_REQ=4, TIMEOUT=8).
// A transaction-level model predicts every output each cycle from the
// accept time of the current operation; directed scenarios add literal
// expectations, then a randomized phase exercises the model further.
module tb_fpu_div_sched;

  localparam int X  = 32;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clrn = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*X-1:0]  req_a;
  logic [N*X-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '0;
  logic [X-1:0]    resp_out;
  logic            resp_overflow, resp_underflow, resp_timeout;
  logic [X-1:0]    div_a, div_b;
  logic            div_start;
  logic            div_done = 1'b0;
  logic [X-1:0]    div_out = '0;
  logic            div_overflow = 1'b0, div_underflow = 1'b0;
  logic            busy;

  logic [X-1:0]    a_in [N];
  logic [X-1:0]    b_in [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*X +: X] = a_in[i];
      req_b[i*X +: X] = b_in[i];
    end
  end

  fpu_div_sched #(.X(X), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
    .resp_overflow(resp_overflow), .resp_underflow(resp_underflow),
    .resp_timeout(resp_timeout),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_done(div_done),
    .div_out(div_out), .div_overflow(div_overflow), .div_underflow(div_underflow),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Divider stand-in: latency 0 means it never answers.
  int          div_lat = 2;
  bit          div_pending = 0;
  int          div_due = 0;
  logic [X-1:0] div_res = '0;
  bit          res_ovf = 0, res_unf = 0;
  bit          force_done = 0;
  bit          start_seen = 0;

  // Transaction model state.
  bit          model_on = 0;
  bit          m_busy = 0, m_div0 = 0, m_have = 0;
  int          m_owner = 0, m_last = N - 1, m_age = 0;
  logic [X-1:0] m_a = '0, m_b = '0, m_out = '0;
  bit          m_ovf = 0, m_unf = 0, m_tmo = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rrPick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Advance one clock; the divider stand-in reacts to the start pulse it saw.
  task automatic tick();
    @(negedge clk);
    start_seen = (div_start === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    div_done = 1'b0;
    if (clrn) div_pending = 0;
    else begin
      if (start_seen && div_lat > 0) begin
        div_pending = 1;
        div_due = cyc - 1 + div_lat;
      end
      if (div_pending && cyc == div_due) begin
        div_done = 1'b1;
        div_out = div_res;
        div_overflow = res_ovf;
        div_underflow = res_unf;
        div_pending = 0;
      end
    end
    if (force_done) begin
      div_done = 1'b1;
      div_out = 32'h12345678;
      force_done = 0;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] rr);
    req_valid = v;
    resp_ready = rr;
  endtask

  task automatic applyReset();
    clrn = 1'b1;
    tick();
    tick();
    clrn = 1'b0;
  endtask

  // Per-cycle compare against the model, then advance the model to the next cycle.
  initial begin
    logic [N-1:0] e_rr, e_rv;
    int p;
    forever begin
      @(negedge clk);
      if (model_on) begin
        p = rrPick(m_last, req_valid);
        e_rr = '0;
        if (!m_busy && !clrn && p >= 0) e_rr[p] = 1'b1;
        e_rv = '0;
        if (m_busy && m_have) e_rv[m_owner] = 1'b1;
        checkOutput("req_ready", req_ready, e_rr);
        checkOutput("resp_valid", resp_valid, e_rv);
        checkOutput("div_start", div_start, m_busy && !m_div0 && !m_have && m_age == 1);
        checkOutput("busy", busy, m_busy);
        if (e_rv != 0) begin
          checkOutput("resp_out", resp_out, m_out);
          checkOutput("resp_overflow", resp_overflow, m_ovf);
          checkOutput("resp_underflow", resp_underflow, m_unf);
          checkOutput("resp_timeout", resp_timeout, m_tmo);
        end
        if (m_busy && !m_div0 && !m_have) begin
          checkOutput("div_a", div_a, m_a);
          checkOutput("div_b", div_b, m_b);
        end
        if (clrn) begin
          m_busy = 0; m_have = 0; m_last = N - 1;
        end else if (!m_busy) begin
          if (p >= 0) begin
            m_busy = 1; m_owner = p; m_age = 1; m_have = 0;
            m_a = a_in[p]; m_b = b_in[p];
            m_div0 = (m_b[X-2:0] == 0);
            if (m_div0) begin
              m_have = 1;
              m_out = ((m_a ^ m_b) & 32'h8000_0000) | 32'h7F80_0000;
              m_ovf = 1; m_unf = 0; m_tmo = 0;
            end
          end
        end else begin
          if (m_have) begin
            if (resp_ready[m_owner]) begin
              m_busy = 0;
              m_last = m_owner;
            end
          end else if (!m_div0 && m_age >= 2) begin
            if (div_done) begin
              m_have = 1; m_out = div_out; m_ovf = div_overflow; m_unf = div_underflow; m_tmo = 0;
            end else if (m_age == TO + 1) begin
              m_have = 1; m_out = '0; m_ovf = 0; m_unf = 0; m_tmo = 1;
            end
          end
          m_age++;
        end
      end
    end
  end

  initial begin
    int order [5];
    int n_acc;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      a_in[i] = 32'h3F80_0000;
      b_in[i] = 32'h3F80_0000;
    end

    // Reset: req_ready held low even with every requester valid.
    req_valid = '1;
    tick();
    model_on = 1;
    tick();
    #1;
    checkOutput("reset_req_ready", req_ready, 4'b0000);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_resp_valid", resp_valid, 4'b0000);
    checkOutput("reset_resp_out", resp_out, 32'h0);
    checkOutput("reset_div_start", div_start, 1'b0);
    checkOutput("reset_div_a", div_a, 32'h0);
    clrn = 1'b0;
    req_valid = '0;

    // Single op: 3.0 / 1.0, divider latency 5.
    a_in[0] = 32'h4040_0000; b_in[0] = 32'h3F80_0000;
    div_lat = 5; div_res = 32'h4040_0000; res_ovf = 0; res_unf = 0;
    applyStimulus(4'b0001, 4'b0000);
    #1 checkOutput("single_accept", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    #1 checkOutput("single_start_c1", div_start, 1'b1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      #1 checkOutput("single_no_resp", resp_valid, 4'b0000);
    end
    tick();
    #1;
    checkOutput("single_resp_c7", resp_valid, 4'b0001);
    checkOutput("single_out", resp_out, 32'h4040_0000);
    checkOutput("single_flags", {resp_overflow, resp_underflow, resp_timeout}, 3'b000);
    applyStimulus(4'b0000, 4'b0001);
    tick();
    #1 checkOutput("single_idle", busy, 1'b0);

    // Round-robin with everyone valid and responses always accepted.
    applyReset();
    div_lat = 2;
    applyStimulus(4'b1111, 4'b1111);
    n_acc = 0;
    for (int c = 0; c < 60 && n_acc < 5; c++) begin
      #1;
      if (req_ready != 0) begin
        checkOutput("rr_onehot", $countones(req_ready), 1);
        for (int i = 0; i < N; i++) if (req_ready[i]) order[n_acc] = i;
        n_acc++;
      end
      tick();
    end
    checkOutput("rr_accepts", n_acc, 5);
    for (int i = 0; i < 5; i++) checkOutput("rr_order", order[i], exp_order[i]);

    // Divide by zero: -2.0 / -0.0 answered in one cycle.
    applyReset();
    a_in[2] = 32'hC000_0000; b_in[2] = 32'h8000_0000;
    applyStimulus(4'b0100, 4'b0000);
    #1 checkOutput("div0_accept", req_ready, 4'b0100);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    #1;
    checkOutput("div0_resp_valid", resp_valid, 4'b0100);
    checkOutput("div0_out", resp_out, 32'h7F80_0000);
    checkOutput("div0_flags", {resp_overflow, resp_underflow, resp_timeout}, 3'b100);
    checkOutput("div0_no_start", div_start, 1'b0);
    applyStimulus(4'b0000, 4'b0100);
    tick();

    // Timeout: divider silent, then a late done is ignored.
    applyReset();
    div_lat = 0;
    a_in[1] = 32'h4000_0000; b_in[1] = 32'h4000_0000;
    applyStimulus(4'b0010, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    for (int i = 2; i <= 9; i++) tick();
    #1 checkOutput("tmo_not_yet_c9", resp_valid, 4'b0000);
    tick();
    #1;
    checkOutput("tmo_resp_c10", resp_valid, 4'b0010);
    checkOutput("tmo_flag", resp_timeout, 1'b1);
    checkOutput("tmo_out", resp_out, 32'h0);
    force_done = 1;
    tick();
    tick();
    #1;
    checkOutput("tmo_late_done_out", resp_out, 32'h0);
    checkOutput("tmo_late_done_flag", resp_timeout, 1'b1);
    applyStimulus(4'b0000, 4'b0010);
    tick();
    div_lat = 3; div_res = 32'h3FC0_0000;
    a_in[2] = 32'h4040_0000; b_in[2] = 32'h4000_0000;
    applyStimulus(4'b0100, 4'b0000);
    #1 checkOutput("tmo_next_accept", req_ready, 4'b0100);
    for (int i = 1; i <= 5; i++) begin
      tick();
      applyStimulus(4'b0000, 4'b0000);
    end
    #1;
    checkOutput("tmo_next_resp", resp_valid, 4'b0100);
    checkOutput("tmo_next_out", resp_out, 32'h3FC0_0000);
    checkOutput("tmo_next_flag", resp_timeout, 1'b0);

    // Backpressure: response held for 10 cycles while others wait.
    applyReset();
    div_lat = 2; div_res = 32'h3F00_0000;
    a_in[3] = 32'h3F80_0000; b_in[3] = 32'h4000_0000;
    applyStimulus(4'b1000, 4'b0000);
    tick();
    applyStimulus(4'b0111, 4'b0000);
    for (int i = 2; i <= 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("bp_valid", resp_valid, 4'b1000);
      checkOutput("bp_out", resp_out, 32'h3F00_0000);
      checkOutput("bp_req_ready", req_ready, 4'b0000);
      tick();
    end
    applyStimulus(4'b0111, 4'b1000);
    tick();
    #1;
    checkOutput("bp_idle", busy, 1'b0);
    checkOutput("bp_next_pick", req_ready, 4'b0001);

    // Reset in the middle of WAIT drops the operation.
    applyReset();
    div_lat = 0;
    b_in[2] = 32'h4000_0000;
    applyStimulus(4'b0100, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    for (int i = 2; i <= 4; i++) tick();
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
    div_lat = 2;
    applyStimulus(4'b1111, 4'b0000);
    #1;
    checkOutput("rst_wait_busy", busy, 1'b0);
    checkOutput("rst_wait_resp", resp_valid, 4'b0000);
    checkOutput("rst_wait_pick", req_ready, 4'b0001);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        a_in[i] = $urandom;
        if ($urandom_range(0, 7) == 0) b_in[i] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h0;
        else b_in[i] = $urandom;
      end
      req_valid  = N'($urandom);
      resp_ready = N'($urandom | $urandom);
      clrn       = ($urandom_range(0, 99) == 0);
      div_lat    = $urandom_range(1, TO + 2);
      div_res    = $urandom;
      res_ovf    = $urandom_range(0, 1);
      res_unf    = $urandom_range(0, 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
